// File: rtl/heap_sift_stage.sv
// heap_sift_stage: one level of a pipelined K-ary heap sorter (sift-down node).
// Optional macro HEAP_SIFT_STATS_EN adds keep_cnt/push_cnt outcome counters.
module heap_sift_stage #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 1,
  parameter int unsigned BRANCH_BITS = 1,
  parameter bit          DESCENDING  = 1'b0,
  parameter bit          LAST_LEVEL  = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  init,
  output logic                                  init_done,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ADDR_WIDTH-1:0]                 in_addr,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  output logic [ADDR_WIDTH-1:0]                 um_addr,
  output logic [DATA_WIDTH-1:0]                 um_din,
  output logic                                  um_we,
  output logic [ADDR_WIDTH-1:0]                 cm_addr,
  output logic                                  cm_re,
  input  logic [(DATA_WIDTH<<BRANCH_BITS)-1:0]  cm_dout,
  output logic                                  nl_valid,
  output logic [ADDR_WIDTH+BRANCH_BITS-1:0]     nl_addr,
  output logic [DATA_WIDTH-1:0]                 nl_data
`ifdef HEAP_SIFT_STATS_EN
  ,
  output logic [31:0]                           keep_cnt,
  output logic [31:0]                           push_cnt
`endif
);

  localparam int unsigned ARITY = 2 ** BRANCH_BITS;
  localparam logic [ADDR_WIDTH-1:0] LAST_SLOT = {ADDR_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] SENTINEL  =
    DESCENDING ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_RESET_WAIT = 3'd0,
    S_IDLE       = 3'd1,
    S_CMP        = 3'd2,
    S_GAP        = 3'd3,
    S_INIT       = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [ADDR_WIDTH-1:0]   r_init_cnt;
  logic                    r_init_done;
  logic [DATA_WIDTH-1:0]   w_best;
  logic [BRANCH_BITS-1:0]  w_best_idx;
  logic                    w_keep;
  logic                    w_accept;

  // Strict ordering test: a wins over b.
  function automatic logic f_beats(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
    return DESCENDING ? (a > b) : (a < b);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_RESET_WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; init overrides everything, including a token in flight.
  always_comb begin
    w_next_state = r_state;
    if (init) begin
      w_next_state = S_INIT;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid) w_next_state = S_CMP;
        S_CMP:   w_next_state = S_GAP;
        S_GAP:   w_next_state = S_IDLE;
        S_INIT:  if (r_init_cnt == LAST_SLOT) w_next_state = S_IDLE;
        default: w_next_state = S_RESET_WAIT;
      endcase
    end
  end

  // Lowest-index child that strictly beats every lower-indexed candidate.
  always_comb begin
    w_best     = cm_dout[DATA_WIDTH-1:0];
    w_best_idx = '0;
    for (int unsigned i = 1; i < ARITY; i++) begin
      if (f_beats(cm_dout[i*DATA_WIDTH +: DATA_WIDTH], w_best)) begin
        w_best     = cm_dout[i*DATA_WIDTH +: DATA_WIDTH];
        w_best_idx = BRANCH_BITS'(i);
      end
    end
  end

  assign w_keep = LAST_LEVEL || !f_beats(w_best, r_data);

  // Output logic; memory and next-level ports follow cm_dout in the CMP cycle.
  always_comb begin
    in_ready = 1'b0;
    cm_re    = 1'b0;
    cm_addr  = '0;
    um_we    = 1'b0;
    um_addr  = '0;
    um_din   = '0;
    nl_valid = 1'b0;
    nl_addr  = '0;
    nl_data  = '0;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!init) begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_accept = 1'b1;
            cm_re    = !LAST_LEVEL;
            cm_addr  = in_addr;
          end
        end
      end
      S_CMP: begin
        if (!init) begin
          um_we   = 1'b1;
          um_addr = r_addr;
          if (w_keep) begin
            um_din = r_data;
          end else begin
            um_din   = w_best;
            nl_valid = 1'b1;
            nl_addr  = {r_addr, w_best_idx};
            nl_data  = r_data;
          end
        end
      end
      S_INIT: begin
        um_we   = 1'b1;
        um_addr = r_init_cnt;
        um_din  = SENTINEL;
      end
      default: ;
    endcase
  end

  // Token capture, init sweep counter and the done pulse.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr      <= '0;
      r_data      <= '0;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= (r_state == S_INIT) && !init && (r_init_cnt == LAST_SLOT);
      if (init) begin
        r_init_cnt <= '0;
      end else if (r_state == S_INIT) begin
        r_init_cnt <= r_init_cnt + ADDR_WIDTH'(1);
      end
      if (w_accept) begin
        r_addr <= in_addr;
        r_data <= in_data;
      end
    end
  end

  assign init_done = r_init_done;

`ifdef HEAP_SIFT_STATS_EN
  // Saturating outcome counters; a dropped token (init in CMP) is not counted.
  always_ff @(posedge clk) begin
    if (!rstn || init) begin
      keep_cnt <= '0;
      push_cnt <= '0;
    end else if (r_state == S_CMP) begin
      if (w_keep) begin
        if (keep_cnt != 32'hFFFF_FFFF) keep_cnt <= keep_cnt + 32'd1;
      end else begin
        if (push_cnt != 32'hFFFF_FFFF) push_cnt <= push_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_heap_sift_stage.sv
// Scoreboard bench for heap_sift_stage: a min-heap and a max-heap instance
// share stimulus; each has its own child RAM model and expectation queues.
`timescale 1ns/1ps
module tb_heap_sift_stage;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 1;
  localparam int unsigned BB = 1;
  localparam int unsigned CW = DW * 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, init, in_valid;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;

  logic init_done_mn, in_ready_mn, um_we_mn, cm_re_mn, nl_valid_mn;
  logic [AW-1:0] um_addr_mn, cm_addr_mn;
  logic [DW-1:0] um_din_mn, nl_data_mn;
  logic [CW-1:0] cm_dout_mn;
  logic [AW+BB-1:0] nl_addr_mn;

  logic init_done_mx, in_ready_mx, um_we_mx, cm_re_mx, nl_valid_mx;
  logic [AW-1:0] um_addr_mx, cm_addr_mx;
  logic [DW-1:0] um_din_mx, nl_data_mx;
  logic [CW-1:0] cm_dout_mx;
  logic [AW+BB-1:0] nl_addr_mx;

`ifdef HEAP_SIFT_STATS_EN
  logic [31:0] keep_cnt_mn, push_cnt_mn, keep_cnt_mx, push_cnt_mx;
`endif

  heap_sift_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BRANCH_BITS(BB),
                    .DESCENDING(1'b0), .LAST_LEVEL(1'b0)) u_dut_mn (
    .clk(clk), .rstn(rstn), .init(init), .init_done(init_done_mn),
    .in_valid(in_valid), .in_ready(in_ready_mn), .in_addr(in_addr), .in_data(in_data),
    .um_addr(um_addr_mn), .um_din(um_din_mn), .um_we(um_we_mn),
    .cm_addr(cm_addr_mn), .cm_re(cm_re_mn), .cm_dout(cm_dout_mn),
    .nl_valid(nl_valid_mn), .nl_addr(nl_addr_mn), .nl_data(nl_data_mn)
`ifdef HEAP_SIFT_STATS_EN
    , .keep_cnt(keep_cnt_mn), .push_cnt(push_cnt_mn)
`endif
  );

  heap_sift_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BRANCH_BITS(BB),
                    .DESCENDING(1'b1), .LAST_LEVEL(1'b0)) u_dut_mx (
    .clk(clk), .rstn(rstn), .init(init), .init_done(init_done_mx),
    .in_valid(in_valid), .in_ready(in_ready_mx), .in_addr(in_addr), .in_data(in_data),
    .um_addr(um_addr_mx), .um_din(um_din_mx), .um_we(um_we_mx),
    .cm_addr(cm_addr_mx), .cm_re(cm_re_mx), .cm_dout(cm_dout_mx),
    .nl_valid(nl_valid_mx), .nl_addr(nl_addr_mx), .nl_data(nl_data_mx)
`ifdef HEAP_SIFT_STATS_EN
    , .keep_cnt(keep_cnt_mx), .push_cnt(push_cnt_mx)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Child bank contents seen by both instances (level addr = {slot, child}).
  logic [DW-1:0] child_mem [4];

  always @(posedge clk) begin
    if (cm_re_mn) cm_dout_mn <= {child_mem[{cm_addr_mn, 1'b1}], child_mem[{cm_addr_mn, 1'b0}]};
    if (cm_re_mx) cm_dout_mx <= {child_mem[{cm_addr_mx, 1'b1}], child_mem[{cm_addr_mx, 1'b0}]};
  end

  // Reference model of one compare, written from the ordering rules.
  function automatic logic f_idx(input logic a, input bit desc);
    logic [DW-1:0] c0, c1;
    c0 = child_mem[{a, 1'b0}];
    c1 = child_mem[{a, 1'b1}];
    return desc ? (c1 > c0) : (c1 < c0);
  endfunction

  function automatic logic [DW-1:0] f_best(input logic a, input bit desc);
    return f_idx(a, desc) ? child_mem[{a, 1'b1}] : child_mem[{a, 1'b0}];
  endfunction

  function automatic logic f_keep(input logic a, input logic [DW-1:0] d, input bit desc);
    return desc ? (d >= f_best(a, desc)) : (d <= f_best(a, desc));
  endfunction

  logic [AW+DW-1:0]    q_um_mn [$];
  logic [AW+BB+DW-1:0] q_nl_mn [$];
  logic [AW+DW-1:0]    q_um_mx [$];
  logic [AW+BB+DW-1:0] q_nl_mx [$];
  bit lat_mn, lat_mx;
  int exp_keep_mn, exp_push_mn, exp_keep_mx, exp_push_mx;

  // Min-heap monitor: pop/compare outputs, then push predictions for new accepts.
  always @(negedge clk) begin
    if (mon_en) begin
      if (lat_mn) check_eq("mn_um_latency", 32'(um_we_mn), 32'd1);
      if (um_we_mn) begin
        if (q_um_mn.size() == 0) check_eq("mn_um_unexpected", 32'(um_we_mn), 32'd0);
        else begin
          check_eq("mn_um", 32'({um_addr_mn, um_din_mn}), 32'(q_um_mn[0]));
          q_um_mn.delete(0);
        end
      end
      if (nl_valid_mn) begin
        if (q_nl_mn.size() == 0) check_eq("mn_nl_unexpected", 32'(nl_valid_mn), 32'd0);
        else begin
          check_eq("mn_nl", 32'({nl_addr_mn, nl_data_mn}), 32'(q_nl_mn[0]));
          q_nl_mn.delete(0);
        end
      end
      lat_mn <= 1'b0;
      if (!rstn || init) begin
        exp_keep_mn <= 0;
        exp_push_mn <= 0;
        if (rstn) begin
          q_um_mn.push_back({1'b0, 8'hFF});
          q_um_mn.push_back({1'b1, 8'hFF});
        end
      end else if (in_valid && in_ready_mn) begin
        check_eq("mn_cm_re", 32'(cm_re_mn), 32'd1);
        check_eq("mn_cm_addr", 32'(cm_addr_mn), 32'(in_addr));
        lat_mn <= 1'b1;
        if (f_keep(in_addr, in_data, 1'b0)) begin
          q_um_mn.push_back({in_addr, in_data});
          exp_keep_mn <= exp_keep_mn + 1;
        end else begin
          q_um_mn.push_back({in_addr, f_best(in_addr, 1'b0)});
          q_nl_mn.push_back({in_addr, f_idx(in_addr, 1'b0), in_data});
          exp_push_mn <= exp_push_mn + 1;
        end
      end
    end
  end

  // Max-heap monitor, same structure with the opposite ordering and zero sentinel.
  always @(negedge clk) begin
    if (mon_en) begin
      if (lat_mx) check_eq("mx_um_latency", 32'(um_we_mx), 32'd1);
      if (um_we_mx) begin
        if (q_um_mx.size() == 0) check_eq("mx_um_unexpected", 32'(um_we_mx), 32'd0);
        else begin
          check_eq("mx_um", 32'({um_addr_mx, um_din_mx}), 32'(q_um_mx[0]));
          q_um_mx.delete(0);
        end
      end
      if (nl_valid_mx) begin
        if (q_nl_mx.size() == 0) check_eq("mx_nl_unexpected", 32'(nl_valid_mx), 32'd0);
        else begin
          check_eq("mx_nl", 32'({nl_addr_mx, nl_data_mx}), 32'(q_nl_mx[0]));
          q_nl_mx.delete(0);
        end
      end
      lat_mx <= 1'b0;
      if (!rstn || init) begin
        exp_keep_mx <= 0;
        exp_push_mx <= 0;
        if (rstn) begin
          q_um_mx.push_back({1'b0, 8'h00});
          q_um_mx.push_back({1'b1, 8'h00});
        end
      end else if (in_valid && in_ready_mx) begin
        check_eq("mx_cm_re", 32'(cm_re_mx), 32'd1);
        check_eq("mx_cm_addr", 32'(cm_addr_mx), 32'(in_addr));
        lat_mx <= 1'b1;
        if (f_keep(in_addr, in_data, 1'b1)) begin
          q_um_mx.push_back({in_addr, in_data});
          exp_keep_mx <= exp_keep_mx + 1;
        end else begin
          q_um_mx.push_back({in_addr, f_best(in_addr, 1'b1)});
          q_nl_mx.push_back({in_addr, f_idx(in_addr, 1'b1), in_data});
          exp_push_mx <= exp_push_mx + 1;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'({in_ready_mn, in_ready_mx}), 32'd0);
    check_eq({tag, "_um"}, 32'({um_we_mn, um_we_mx, um_din_mn, um_din_mx}), 32'd0);
    check_eq({tag, "_nl"}, 32'({nl_valid_mn, nl_valid_mx, nl_data_mn, nl_data_mx}), 32'd0);
    check_eq({tag, "_cm"}, 32'({cm_re_mn, cm_re_mx, cm_addr_mn, cm_addr_mx}), 32'd0);
    check_eq({tag, "_done"}, 32'({init_done_mn, init_done_mx}), 32'd0);
  endtask

  task automatic do_init();
    @(posedge clk); #1 init = 1'b1;
    @(posedge clk); #1 init = 1'b0;
    @(negedge clk);
    check_eq("init_w0_we", 32'({um_we_mn, um_we_mx}), 32'h3);
    @(negedge clk);
    check_eq("init_w1_we", 32'({um_we_mn, um_we_mx}), 32'h3);
    @(negedge clk);
    check_eq("init_done_pulse", 32'({init_done_mn, init_done_mx}), 32'h3);
    check_eq("init_ready", 32'({in_ready_mn, in_ready_mx}), 32'h3);
    @(negedge clk);
    check_eq("init_done_clear", 32'({init_done_mn, init_done_mx}), 32'h0);
    check_eq("init_q_empty", 32'(q_um_mn.size() + q_um_mx.size()), 32'd0);
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = in_ready_mn;
    end
    check_eq("send_accept", 32'(got), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic set_children(input logic [DW-1:0] c0, c1, c2, c3);
    child_mem[0] = c0; child_mem[1] = c1; child_mem[2] = c2; child_mem[3] = c3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    rstn = 1'b0; init = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    set_children(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check_idle_outputs("pre_init");
    in_valid = 1'b0;

    do_init();

    // Directed compares from the block description.
    set_children(8'h20, 8'h30, 8'h25, 8'h18);
    send(1'b0, 8'h10);
    send(1'b1, 8'h40);
    set_children(8'h18, 8'h18, 8'h25, 8'h18);
    send(1'b0, 8'h18);
    set_children(8'hFF, 8'hFF, 8'h00, 8'h00);
    send(1'b0, 8'h80);
    send(1'b1, 8'h80);

    // Random keys drawn from a small set so ties and sentinels are common.
    for (int n = 0; n < 10; n++) begin
      set_children(8'($urandom_range(0, 3) * 85), 8'($urandom_range(0, 3) * 85),
                   8'($urandom_range(0, 3) * 85), 8'($urandom_range(0, 3) * 85));
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3) * 85));
    end

    // Back-to-back requests: one accept every third cycle.
    set_children(8'h40, 8'h50, 8'h05, 8'h60);
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b1; in_addr = 1'b1; in_data = 8'h30;
    accepts = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_eq("hold_ready", 32'(in_ready_mn), 32'((i % 3) == 0));
      if (in_ready_mn) accepts++;
    end
    check_eq("hold_accepts", 32'(accepts), 32'd3);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);

    // Reset asserted while the token is in CMP.
    set_children(8'h11, 8'h22, 8'h33, 8'h44);
    send(1'b0, 8'h55);
    rstn = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 in_valid = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort");
    @(posedge clk); #1 rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_outputs("post_abort");
    end
    in_valid = 1'b0;

    do_init();
    set_children(8'h90, 8'h70, 8'h08, 8'h09);
    send(1'b0, 8'h80);
    send(1'b1, 8'h01);
    send(1'b0, 8'h70);
    repeat (4) @(negedge clk);

    check_eq("mn_q_empty", 32'(q_um_mn.size() + q_nl_mn.size()), 32'd0);
    check_eq("mx_q_empty", 32'(q_um_mx.size() + q_nl_mx.size()), 32'd0);
`ifdef HEAP_SIFT_STATS_EN
    check_eq("mn_keep_cnt", keep_cnt_mn, 32'(exp_keep_mn));
    check_eq("mn_push_cnt", push_cnt_mn, 32'(exp_push_mn));
    check_eq("mx_keep_cnt", keep_cnt_mx, 32'(exp_keep_mx));
    check_eq("mx_push_cnt", push_cnt_mx, 32'(exp_push_mx));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
